// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Host-side controller for an 8-bit asynchronous SRAM with active-low
// cs/we/oe strobes. It turns single req/ready host transactions into strobe
// sequences. oe_n and we_n are never low at the same time. The data bus is
// driven only in the three write states, so the controller never drives it
// while the SRAM may be driving it.
//
// Optional feature macro: SRAM_CTRL_WORD_EN
//   Defined   : the host port is 2*DATA_W wide and addr is an (ADDR_W-1)-bit word
//               address. Each host operation performs two byte accesses: the low
//               byte at {addr,0}, then the high byte at {addr,1}.
//   Undefined : single-byte operations. No byte-sequencing logic is built.
//
// Ports
//   clk        in    system clock, rising edge
//   n_reset    in    asynchronous active-low reset
//   req        in    host request, held until accepted (accept = req & ready)
//   wr         in    1 = write, 0 = read; sampled at accept
//   addr       in    host address (byte address, or word address in word mode)
//   wdata      in    write data
//   ready      out   controller idle (state == IDLE)
//   rdata      out   read data, held until the next read completes
//   rvalid     out   one-cycle pulse when rdata is updated
//   sram_cs_n  out   SRAM chip select (registered)
//   sram_we_n  out   SRAM write enable (registered)
//   sram_oe_n  out   SRAM output enable (registered)
//   sram_addr  out   SRAM byte address (registered)
//   sram_data  inout SRAM data; driven only in WR_SETUP/WR_PULSE/WR_HOLD
//   dbg_state  out   current FSM state (IDLE=0, RD_ACT=1, RD_TURN=2,
//                    WR_SETUP=3, WR_PULSE=4, WR_HOLD=5)
//
// Handshake: the host raises req with wr/addr/wdata stable. The transaction is
// accepted on the rising clk edge where req and ready are both high. req is
// ignored while ready is low. A read returns exactly one rvalid pulse.
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                req,
    input  logic                wr,
`ifdef SRAM_CTRL_WORD_EN
    input  logic [ADDR_W-2:0]   addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [2*DATA_W-1:0] rdata,
`else
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
`endif
    output logic                ready,
    output logic                rvalid,
    output logic                sram_cs_n,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_data,
    output logic [2:0]          dbg_state
);

`ifdef SRAM_CTRL_WORD_EN
    localparam int HD_W = 2 * DATA_W;
`else
    localparam int HD_W = DATA_W;
`endif
    localparam int CNT_MAX_RW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_MAX    = (CNT_MAX_RW > TURN) ? CNT_MAX_RW : TURN;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ACT   = 3'd1,
        S_RD_TURN  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]  wbyte_q, wbyte_d;
    logic [HD_W-1:0]    rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               cs_n_q, cs_n_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               drive_q, drive_d;
`ifdef SRAM_CTRL_WORD_EN
    logic               byte_sel_q, byte_sel_d;  // 0 = low byte, 1 = high byte
    logic [DATA_W-1:0]  lo_q, lo_d;              // low byte captured by the first read phase
    logic [DATA_W-1:0]  whi_q, whi_d;            // high write byte held for the second write
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        wbyte_d     = wbyte_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
`ifdef SRAM_CTRL_WORD_EN
        byte_sel_d  = byte_sel_q;
        lo_d        = lo_q;
        whi_d       = whi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
`ifdef SRAM_CTRL_WORD_EN
                    sram_addr_d = {addr, 1'b0};
                    byte_sel_d  = 1'b0;
                    wbyte_d     = wdata[DATA_W-1:0];
                    whi_d       = wdata[2*DATA_W-1:DATA_W];
`else
                    sram_addr_d = addr;
                    wbyte_d     = wdata;
`endif
                    if (wr) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD_ACT;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD_ACT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef SRAM_CTRL_WORD_EN
                    if (!byte_sel_q) begin
                        // Low byte done. Stay in RD_ACT for the high byte; no turnaround between the phases.
                        lo_d        = sram_data;
                        byte_sel_d  = 1'b1;
                        sram_addr_d = {sram_addr_q[ADDR_W-1:1], 1'b1};
                        cnt_d       = CNT_W'(RD_WAIT - 1);
                    end else begin
                        rdata_d  = {sram_data, lo_q};
                        rvalid_d = 1'b1;
                        state_d  = S_RD_TURN;
                        cnt_d    = CNT_W'(TURN - 1);
                    end
`else
                    rdata_d  = sram_data;
                    rvalid_d = 1'b1;
                    state_d  = S_RD_TURN;
                    cnt_d    = CNT_W'(TURN - 1);
`endif
                end
            end
            S_RD_TURN: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = S_IDLE;
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = CNT_W'(WR_WAIT - 1);
            end
            S_WR_PULSE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
`ifdef SRAM_CTRL_WORD_EN
                if (!byte_sel_q) begin
                    // Second full write sequence, for the high byte. cs_n stays low.
                    // The address and data change in WR_SETUP, while we_n is high.
                    byte_sel_d  = 1'b1;
                    sram_addr_d = {sram_addr_q[ADDR_W-1:1], 1'b1};
                    wbyte_d     = whi_q;
                    state_d     = S_WR_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state and then registered.
        // This keeps them glitch-free and aligned with state_q.
        cs_n_d  = (state_d == S_IDLE) || (state_d == S_RD_TURN);
        oe_n_d  = (state_d != S_RD_ACT);
        we_n_d  = (state_d != S_WR_PULSE);
        drive_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            wbyte_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            drive_q     <= 1'b0;
`ifdef SRAM_CTRL_WORD_EN
            byte_sel_q  <= 1'b0;
            lo_q        <= '0;
            whi_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sram_addr_q <= sram_addr_d;
            wbyte_q     <= wbyte_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            drive_q     <= drive_d;
`ifdef SRAM_CTRL_WORD_EN
            byte_sel_q  <= byte_sel_d;
            lo_q        <= lo_d;
            whi_q       <= whi_d;
`endif
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign sram_cs_n = cs_n_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_addr = sram_addr_q;
    assign sram_data = drive_q ? wbyte_q : {DATA_W{1'bz}};
    assign dbg_state = state_q;

endmodule
